// File: rtl/buffer_loader_pkg.sv
// ---------------------------------------------------------------------------
// buffer_loader_pkg
//   Shared definitions for the row buffer fill path:
//     - default stream beat width, row width and row count (shared with the
//       row register buffer itself),
//     - the beats-per-row derivation,
//     - the loader FSM state encoding.
//   Optional feature macro used by files importing this package:
//     LOADER_MSB_FIRST_EN - pack beat 0 into the MSB slot instead of the LSB.
// ---------------------------------------------------------------------------
package buffer_loader_pkg;

  localparam int DEF_IN_W  = 64;
  localparam int DEF_WIDTH = 384;
  localparam int DEF_DEPTH = 16;

  // Number of stream beats that make up one buffer row. The row width must
  // be an integer multiple of the beat width.
  function automatic int beats_per_row(input int width, input int in_w);
    return width / in_w;
  endfunction

  localparam int DEF_BEATS = beats_per_row(DEF_WIDTH, DEF_IN_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/buffer_loader_row_packer.sv
// ---------------------------------------------------------------------------
// buffer_loader_row_packer
//   Collects BEATS consecutive stream beats into one row-wide assembly
//   register. o_row_full strobes in the cycle the last beat of a row is
//   accepted; o_row is the complete row including that beat, so the caller
//   can register it on the same edge.
//   Macro: LOADER_MSB_FIRST_EN - beat k lands in slot BEATS-1-k instead of k.
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_clear     restart packing at beat 0 (new load)
//   i_accept    a beat is transferred this cycle
//   i_data      beat payload
//   o_row_full  last beat of the current row accepted this cycle
//   o_row       assembled row (combinational merge of register + this beat)
// ---------------------------------------------------------------------------
module buffer_loader_row_packer
  import buffer_loader_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_accept,
  input  logic [IN_W-1:0]  i_data,
  output logic             o_row_full,
  output logic [WIDTH-1:0] o_row
);

  localparam int BEATS  = beats_per_row(WIDTH, IN_W);
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  logic [BCNT_W-1:0] beat_cnt_reg;
  logic [WIDTH-1:0]  row_reg;
  logic [WIDTH-1:0]  row_next;
  logic [BEATS-1:0]  slot_hit;

  // Each slot picks up the incoming beat when the beat counter points at
  // the beat index that maps onto it; otherwise it keeps its contents.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
`ifdef LOADER_MSB_FIRST_EN
    localparam int BEAT_IDX = BEATS - 1 - gi;
`else
    localparam int BEAT_IDX = gi;
`endif
    assign slot_hit[gi] = i_accept && (beat_cnt_reg == BCNT_W'(BEAT_IDX));
    assign row_next[gi*IN_W +: IN_W] = slot_hit[gi] ? i_data
                                                    : row_reg[gi*IN_W +: IN_W];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_cnt_reg <= '0;
      row_reg      <= '0;
    end else begin
      row_reg <= row_next;
      if (i_clear) begin
        beat_cnt_reg <= '0;
      end else if (i_accept) begin
        beat_cnt_reg <= (beat_cnt_reg == LAST_BEAT) ? '0
                                                    : beat_cnt_reg + BCNT_W'(1);
      end
    end
  end

  assign o_row_full = i_accept && (beat_cnt_reg == LAST_BEAT);
  assign o_row      = row_next;

endmodule

// File: rtl/buffer_loader.sv
// ---------------------------------------------------------------------------
// buffer_loader
//   Fill stage for the row register buffer: accepts a narrow valid/ready
//   stream, packs BEATS beats per row and writes i_rows rows starting at
//   i_base (wrapping modulo DEPTH), then pulses o_done.
//   Macro: LOADER_MSB_FIRST_EN - beat 0 lands in the row's MSB slot.
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   i_start    load request, only honoured in IDLE
//   i_base     first row address, latched on accepted start
//   i_rows     rows to load (0..DEPTH), latched on accepted start
//   i_valid    stream beat valid
//   i_data     stream beat
//   o_ready    beat accepted when i_valid && o_ready
//   o_we       buffer write enable, one pulse per row
//   o_addr_wr  buffer write row (held between writes)
//   o_data_wr  assembled row (held between writes)
//   o_busy     accepted start through the o_done cycle
//   o_done     single-cycle completion pulse
// ---------------------------------------------------------------------------
module buffer_loader
  import buffer_loader_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_rows,
  input  logic              i_valid,
  input  logic [IN_W-1:0]   i_data,
  output logic              o_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr_wr,
  output logic [WIDTH-1:0]  o_data_wr,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W:0]   rows_reg;
  logic [ADDR_W:0]   row_cnt_reg;
  logic [ADDR_W:0]   row_cnt_inc;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_wr_reg;
  logic [WIDTH-1:0]  data_wr_reg;

  logic              start_acc;
  logic              beat_acc;
  logic              row_full;
  logic [WIDTH-1:0]  row_data;
  logic              last_row;

  assign start_acc   = (state_reg == ST_IDLE) && i_start;
  assign beat_acc    = i_valid && o_ready;
  assign row_cnt_inc = row_cnt_reg + (ADDR_W + 1)'(1);
  // The row being completed now is the final one when it brings the count
  // up to the programmed total.
  assign last_row    = (row_cnt_inc == rows_reg);

  buffer_loader_row_packer #(
    .IN_W  (IN_W),
    .WIDTH (WIDTH)
  ) u_row_packer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (start_acc),
    .i_accept   (beat_acc),
    .i_data     (i_data),
    .o_row_full (row_full),
    .o_row      (row_data)
  );

  always_comb begin
    state_next = state_reg;
    o_ready    = 1'b0;
    o_done     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next = (i_rows == '0) ? ST_FLUSH : ST_FILL;
        end
      end
      ST_FILL: begin
        o_ready = 1'b1;
        if (row_full && last_row) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // The final row's write is issued from the output register in this
        // same cycle, so done and the last o_we line up.
        o_done     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Busy covers the accepting start cycle itself, hence the i_start term.
  assign o_busy = (state_reg != ST_IDLE) || (i_start && !i_rst);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      wr_ptr_reg  <= '0;
      rows_reg    <= '0;
      row_cnt_reg <= '0;
      we_reg      <= 1'b0;
      addr_wr_reg <= '0;
      data_wr_reg <= '0;
    end else begin
      state_reg <= state_next;
      we_reg    <= row_full;
      if (start_acc) begin
        wr_ptr_reg  <= i_base;
        rows_reg    <= i_rows;
        row_cnt_reg <= '0;
      end
      if (row_full) begin
        addr_wr_reg <= wr_ptr_reg;
        data_wr_reg <= row_data;
        // Running pointer wraps explicitly so DEPTH need not be a power of 2.
        wr_ptr_reg  <= (wr_ptr_reg == LAST_ADDR) ? '0 : wr_ptr_reg + ADDR_W'(1);
        row_cnt_reg <= row_cnt_inc;
      end
    end
  end

  assign o_we      = we_reg;
  assign o_addr_wr = addr_wr_reg;
  assign o_data_wr = data_wr_reg;

endmodule
